param_cpu: RTL
==============

PARAM_CPU -- requirements
Module: param_cpu

Interface
REQ-001 Parameter DATA_WIDTH, default 8: datapath, register and memory word width.
REQ-002 Parameter ADDR_BITS, default 5: data-memory address width, depth 2**ADDR_BITS.
REQ-003 Parameter NUM_REGS, default 4, power of two >=2: register-file depth; REG_BITS = clog2(NUM_REGS).
REQ-004 Derived localparam INSTR_WIDTH = 2 + 3*REG_BITS + DATA_WIDTH + 4, which is 20 at defaults.
REQ-005 clk  input  1  sole clock; every state element updates on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 instr  input  INSTR_WIDTH  instruction: [type 2][dst REG_BITS][src1 REG_BITS][src2 REG_BITS][offset DATA_WIDTH][opcode 4], MSB first.
REQ-008 instr_valid  input  1  instr is presented.
REQ-009 instr_ready  output  1  core is able to accept an instruction.
REQ-010 done  output  1  one-cycle pulse marking the writeback cycle of the completing instruction.
REQ-011 err  output  1  one-cycle pulse, asserted with done, when an std_op carries an illegal opcode.
REQ-012 flag_z, flag_c  output  1 each  zero flag and carry/borrow flag.
REQ-013 dbg_sel  input  REG_BITS  and  dbg_data  output  DATA_WIDTH: combinational read of regfile[dbg_sel].

Function
REQ-014 Types: 00 NOP, 01 STD_OP (dst = src1 op src2), 10 LOAD (dst = mem[ea]), 11 STORE (mem[ea] = reg[dst]); ea = (reg[src1] + offset) mod 2**ADDR_BITS, so the address wraps.
REQ-015 Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL by 1, 6 SHR by 1, 7 PASS src1; 8-15 are illegal and give result 0 with err=1.
REQ-016 FSM states: IDLE, DECODE, EXECUTE, MEM, WRITEBACK.
REQ-017 FSM transitions:
- IDLE to DECODE when instr_valid=1 and type!=00.
- DECODE to EXECUTE.
- EXECUTE to WRITEBACK for STD_OP; EXECUTE to MEM for LOAD and STORE.
- MEM to WRITEBACK.
- WRITEBACK to IDLE.
- Any unused encoding to IDLE.
REQ-018 instr_ready = 1 only in IDLE; instr is latched on the accept edge; input changes while busy are ignored.
REQ-019 A NOP is accepted and discarded: the FSM stays in IDLE, done is not pulsed, and no state changes.
REQ-020 Latency from the accept edge to the done cycle: STD_OP 3 cycles, LOAD/STORE 4 cycles; issue interval is 4 and 5 cycles.
REQ-021 Source registers are read in DECODE; the ALU result is registered at the end of EXECUTE; the memory is read or written at the end of MEM.
REQ-022 The regfile write to dst (STD_OP, LOAD) occurs on the edge that ends WRITEBACK.
REQ-023 Arithmetic is modulo 2**DATA_WIDTH.
REQ-024 flag_c: carry-out for ADD, borrow for SUB (src1 < src2), 0 for all other opcodes.
REQ-025 flag_z = (result == 0).
REQ-026 Flags update only on STD_OP writeback; they are unchanged by LOAD, STORE and illegal opcodes.
REQ-027 When dst equals src1 or src2, the pre-instruction values are used as operands.
REQ-028 Memory has one port: STORE writes during MEM; LOAD's read data is registered and written back in WRITEBACK.

Reset
REQ-029 While rst=1 on an edge:
- state becomes IDLE, so instr_ready=1 next cycle;
- done=0, err=0, flag_z=0, flag_c=0;
- regfile[i] = i mod 2**DATA_WIDTH.
REQ-030 Reset mid-instruction aborts the instruction with no regfile, flag or memory write.
REQ-031 Memory contents are not reset and survive rst.
REQ-032 rst takes priority over instr_valid on the same edge.

Structure
REQ-033 Package param_cpu_pkg SHALL hold the instruction-type and opcode enumerations, the state enumeration, and the field-offset helper constants.
REQ-034 The ALU SHALL be one sub-module, cpu_alu (combinational, parametrised by DATA_WIDTH, producing result, carry and illegal outputs); regfile and memory stay in param_cpu.

Verification
REQ-035 After reset, ADD dst=1, src1=2, src2=3 -> done 3 cycles after accept, regfile[1]=5, flag_z=0, flag_c=0.
REQ-036 SUB dst=0, src1=1, src2=2 -> regfile[0]=0xFF, flag_c=1, flag_z=0; then XOR dst=2, src1=3, src2=3 -> regfile[2]=0, flag_z=1, flag_c=0.
REQ-037 STORE dst=3, src1=2, offset=8 -> mem[10]=3, done 4 cycles after accept; then LOAD dst=0, src1=2, offset=8 -> regfile[0]=3.
REQ-038 STORE dst=2, src1=1, offset=0xFF -> ea wraps to 0; LOAD dst=3, src1=0 (reg 0 holding 0), offset 0 -> regfile[3]=2.
REQ-039 Assert rst during EXECUTE of ADD dst=1 -> regfile[1]=1, done never pulses, instr_ready=1 the cycle after rst deasserts.
REQ-040 Hold instr_valid=1 with back-to-back ADDs, plus a NOP and opcode 9 -> exactly one accept per IDLE visit; the NOP gives no done; opcode 9 gives dst=0, err=1 and unchanged flags.

Source files
------------

// File: rtl/param_cpu_pkg.sv
// Shared types and instruction-field layout helpers for param_cpu.
// Instruction layout, MSB first: [type][dst][src1][src2][offset][opcode].
package param_cpu_pkg;

    typedef enum logic [1:0] {
        TYPE_NOP   = 2'b00,
        TYPE_STD   = 2'b01,
        TYPE_LOAD  = 2'b10,
        TYPE_STORE = 2'b11
    } instr_type_e;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SHL  = 4'd5,
        OP_SHR  = 4'd6,
        OP_PASS = 4'd7
    } opcode_e;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEM       = 3'd3,
        S_WRITEBACK = 3'd4
    } state_e;

    localparam int TYPE_BITS   = 2;
    localparam int OPCODE_BITS = 4;
    localparam int OFF_OFFSET  = OPCODE_BITS;

    function automatic int instr_width(input int dw, input int rb);
        return TYPE_BITS + 3 * rb + dw + OPCODE_BITS;
    endfunction

    function automatic int off_src2(input int dw);
        return OPCODE_BITS + dw;
    endfunction

    function automatic int off_src1(input int dw, input int rb);
        return OPCODE_BITS + dw + rb;
    endfunction

    function automatic int off_dst(input int dw, input int rb);
        return OPCODE_BITS + dw + 2 * rb;
    endfunction

    function automatic int off_type(input int dw, input int rb);
        return OPCODE_BITS + dw + 3 * rb;
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: eight legal opcodes, carry/borrow out, illegal-opcode flag.
module cpu_alu
    import param_cpu_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [3:0]            op,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  carry,
    output logic                  illegal
);

    logic [DATA_WIDTH:0] wide;

    always_comb begin
        wide    = '0;
        result  = '0;
        carry   = 1'b0;
        illegal = 1'b0;
        case (op)
            OP_ADD: begin
                wide   = {1'b0, a} + {1'b0, b};
                result = wide[DATA_WIDTH-1:0];
                carry  = wide[DATA_WIDTH];
            end
            // The extra MSB of the widened difference is set exactly when a < b.
            OP_SUB: begin
                wide   = {1'b0, a} - {1'b0, b};
                result = wide[DATA_WIDTH-1:0];
                carry  = wide[DATA_WIDTH];
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SHL:  result = a << 1;
            OP_SHR:  result = a >> 1;
            OP_PASS: result = a;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/param_cpu.sv
// Multi-cycle parametrised CPU core: IDLE/DECODE/EXECUTE/MEM/WRITEBACK with
// an internal register file and single-port data memory.
module param_cpu
    import param_cpu_pkg::*;
#(
    parameter  int DATA_WIDTH  = 8,
    parameter  int ADDR_BITS   = 5,
    parameter  int NUM_REGS    = 4,
    localparam int REG_BITS    = $clog2(NUM_REGS),
    localparam int INSTR_WIDTH = instr_width(DATA_WIDTH, REG_BITS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INSTR_WIDTH-1:0] instr,
    input  logic                   instr_valid,
    output logic                   instr_ready,
    output logic                   done,
    output logic                   err,
    output logic                   flag_z,
    output logic                   flag_c,
    input  logic [REG_BITS-1:0]    dbg_sel,
    output logic [DATA_WIDTH-1:0]  dbg_data
);

    localparam int DEPTH    = 1 << ADDR_BITS;
    localparam int TYPE_OFF = off_type(DATA_WIDTH, REG_BITS);
    localparam int DST_OFF  = off_dst(DATA_WIDTH, REG_BITS);
    localparam int SRC1_OFF = off_src1(DATA_WIDTH, REG_BITS);
    localparam int SRC2_OFF = off_src2(DATA_WIDTH);

    state_e                state, state_next;
    instr_type_e           ir_type;
    logic [REG_BITS-1:0]   ir_dst, ir_src1, ir_src2;
    logic [DATA_WIDTH-1:0] ir_offset;
    logic [3:0]            ir_op;

    logic [DATA_WIDTH-1:0] op_a, op_b, st_data, alu_q, ld_q;
    logic                  carry_q, illegal_q;
    logic [ADDR_BITS-1:0]  ea;

    logic [DATA_WIDTH-1:0] alu_res;
    logic                  alu_carry, alu_illegal;

    logic [DATA_WIDTH-1:0] rf  [NUM_REGS];
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic accept;
    assign accept = (state == S_IDLE) && instr_valid
                    && (instr[TYPE_OFF +: TYPE_BITS] != TYPE_NOP);

    assign dbg_data = rf[dbg_sel];

    cpu_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
        .a      (op_a),
        .b      (op_b),
        .op     (ir_op),
        .result (alu_res),
        .carry  (alu_carry),
        .illegal(alu_illegal)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = S_IDLE;
        case (state)
            S_IDLE:      state_next = accept ? S_DECODE : S_IDLE;
            S_DECODE:    state_next = S_EXECUTE;
            S_EXECUTE:   state_next = (ir_type == TYPE_STD) ? S_WRITEBACK : S_MEM;
            S_MEM:       state_next = S_WRITEBACK;
            S_WRITEBACK: state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    always_comb begin
        instr_ready = (state == S_IDLE);
        done        = (state == S_WRITEBACK);
        err         = (state == S_WRITEBACK) && (ir_type == TYPE_STD) && illegal_q;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            ir_type   <= instr_type_e'(instr[TYPE_OFF +: TYPE_BITS]);
            ir_dst    <= instr[DST_OFF +: REG_BITS];
            ir_src1   <= instr[SRC1_OFF +: REG_BITS];
            ir_src2   <= instr[SRC2_OFF +: REG_BITS];
            ir_offset <= instr[OFF_OFFSET +: DATA_WIDTH];
            ir_op     <= instr[OPCODE_BITS-1:0];
        end
        // Operands are snapshotted here, so dst aliasing a source sees old values.
        if (state == S_DECODE) begin
            op_a    <= rf[ir_src1];
            op_b    <= rf[ir_src2];
            st_data <= rf[ir_dst];
        end
        if (state == S_EXECUTE) begin
            alu_q     <= alu_res;
            carry_q   <= alu_carry;
            illegal_q <= alu_illegal;
            ea        <= ADDR_BITS'(op_a) + ADDR_BITS'(ir_offset);
        end
        if (state == S_MEM && ir_type == TYPE_LOAD) begin
            ld_q <= mem[ea];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && state == S_MEM && ir_type == TYPE_STORE) begin
            mem[ea] <= st_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                rf[i] <= DATA_WIDTH'(i);
            end
            flag_z <= 1'b0;
            flag_c <= 1'b0;
        end else if (state == S_WRITEBACK) begin
            case (ir_type)
                TYPE_STD: begin
                    rf[ir_dst] <= alu_q;
                    if (!illegal_q) begin
                        flag_z <= (alu_q == '0);
                        flag_c <= carry_q;
                    end
                end
                TYPE_LOAD: rf[ir_dst] <= ld_q;
                default: ;
            endcase
        end
    end

endmodule
